// File: rtl/mac_operand_streamer.sv
// Operand sequencer for the staged MAC: reads LEN weight/activation pairs and streams them
// as {weight, activation} AXI-Stream beats through a 4-deep FIFO. Optional stats: MAC_STREAMER_STATS_EN.
module mac_operand_streamer #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                    i_aclk,
   input  logic                    i_aresetn,
   input  logic                    i_cmd_valid,
   output logic                    o_cmd_ready,
   input  logic [ADDR_WIDTH-1:0]   i_cmd_w_base,
   input  logic [ADDR_WIDTH-1:0]   i_cmd_a_base,
   input  logic [LEN_WIDTH-1:0]    i_cmd_len,
   input  logic                    i_cmd_bias_en,
   input  logic [DATA_WIDTH-1:0]   i_cmd_bias,
   input  logic [7:0]              i_cmd_id,
   output logic                    o_w_rd_en,
   output logic                    o_a_rd_en,
   output logic [ADDR_WIDTH-1:0]   o_w_rd_addr,
   output logic [ADDR_WIDTH-1:0]   o_a_rd_addr,
   input  logic [DATA_WIDTH-1:0]   i_w_rd_data,
   input  logic [DATA_WIDTH-1:0]   i_a_rd_data,
   output logic                    o_md_axis_tvalid,
   input  logic                    i_md_axis_tready,
   output logic [2*DATA_WIDTH-1:0] o_md_axis_tdata,
   output logic                    o_md_axis_tuser,
   output logic                    o_md_axis_tlast,
   output logic [7:0]              o_md_axis_tid,
   output logic [31:0]             o_stat_beats,
   output logic [31:0]             o_stat_stalls
);

   localparam int TW = 2 * DATA_WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

   state_t                r_state, w_state_next;
   logic [ADDR_WIDTH-1:0] r_w_base, r_a_base;
   logic [LEN_WIDTH-1:0]  r_len, r_k;
   logic [7:0]            r_id;
   logic                  r_inflight, r_inflight_last;

   logic [TW-1:0]         r_fifo_data [4];
   logic                  r_fifo_user [4];
   logic                  r_fifo_last [4];
   logic [7:0]            r_fifo_id   [4];
   logic [1:0]            r_wr_ptr, r_rd_ptr;
   logic [2:0]            r_count;

   logic                  w_accept, w_issue, w_k_last, w_pop, w_credit_ok;
   logic [3:0]            w_occupancy;
   logic                  w_push, w_push_user, w_push_last;
   logic [TW-1:0]         w_push_data;
   logic [7:0]            w_push_id;
   logic [ADDR_WIDTH-1:0] w_w_addr, w_a_addr;

   assign o_cmd_ready = (r_state == S_IDLE) && i_aresetn;
   assign w_accept    = i_cmd_valid && o_cmd_ready;

   // Credit counts the read in flight as already occupying a slot, so reads never overflow the FIFO.
   assign w_occupancy = {1'b0, r_count} + {3'b000, r_inflight};
   assign w_credit_ok = w_occupancy < 4'd4;
   assign w_issue     = (r_state == S_ISSUE) && w_credit_ok;
   assign w_k_last    = (r_k == r_len - LEN_WIDTH'(1));

   assign w_w_addr    = r_w_base + ADDR_WIDTH'(r_k);
   assign w_a_addr    = r_a_base + ADDR_WIDTH'(r_k);
   assign o_w_rd_en   = w_issue;
   assign o_a_rd_en   = w_issue;
   assign o_w_rd_addr = w_issue ? w_w_addr : '0;
   assign o_a_rd_addr = w_issue ? w_a_addr : '0;

   assign o_md_axis_tvalid = (r_count != 3'd0);
   assign o_md_axis_tdata  = r_fifo_data[r_rd_ptr];
   assign o_md_axis_tuser  = r_fifo_user[r_rd_ptr];
   assign o_md_axis_tlast  = r_fifo_last[r_rd_ptr];
   assign o_md_axis_tid    = r_fifo_id[r_rd_ptr];
   assign w_pop            = o_md_axis_tvalid && i_md_axis_tready;

   // Returned read data and the accept-time bias/empty beat can never coincide: reads only occur outside IDLE.
   always_comb begin
      w_push      = 1'b0;
      w_push_data = '0;
      w_push_user = 1'b0;
      w_push_last = 1'b0;
      w_push_id   = r_id;
      if (r_inflight) begin
         w_push      = 1'b1;
         w_push_data = {i_w_rd_data, i_a_rd_data};
         w_push_last = r_inflight_last;
      end else if (w_accept && (i_cmd_bias_en || (i_cmd_len == '0))) begin
         w_push      = 1'b1;
         w_push_data = i_cmd_bias_en ? {{DATA_WIDTH{1'b0}}, i_cmd_bias} : '0;
         w_push_user = i_cmd_bias_en;
         w_push_last = (i_cmd_len == '0);
         w_push_id   = i_cmd_id;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept)
               w_state_next = (i_cmd_len == '0) ? S_DRAIN : S_ISSUE;
         end
         S_ISSUE: begin
            if (w_issue && w_k_last)
               w_state_next = S_DRAIN;
         end
         S_DRAIN: begin
            if ((r_count == 3'd0) && !r_inflight)
               w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_aclk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         r_state         <= S_IDLE;
         r_w_base        <= '0;
         r_a_base        <= '0;
         r_len           <= '0;
         r_k             <= '0;
         r_id            <= '0;
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
      end else begin
         r_state         <= w_state_next;
         r_inflight      <= w_issue;
         r_inflight_last <= w_issue && w_k_last;
         if (w_accept) begin
            r_w_base <= i_cmd_w_base;
            r_a_base <= i_cmd_a_base;
            r_len    <= i_cmd_len;
            r_id     <= i_cmd_id;
            r_k      <= '0;
         end else if (w_issue) begin
            r_k <= r_k + LEN_WIDTH'(1);
         end
      end
   end

   // Storage is cleared on reset so the idle output bus reads as zero.
   always_ff @(posedge i_aclk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         for (int i = 0; i < 4; i++) begin
            r_fifo_data[i] <= '0;
            r_fifo_user[i] <= 1'b0;
            r_fifo_last[i] <= 1'b0;
            r_fifo_id[i]   <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_fifo_data[r_wr_ptr] <= w_push_data;
            r_fifo_user[r_wr_ptr] <= w_push_user;
            r_fifo_last[r_wr_ptr] <= w_push_last;
            r_fifo_id[r_wr_ptr]   <= w_push_id;
            r_wr_ptr              <= r_wr_ptr + 2'd1;
         end
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 2'd1;
         r_count <= r_count + {2'b00, w_push} - {2'b00, w_pop};
      end
   end

`ifdef MAC_STREAMER_STATS_EN
   logic [31:0] r_stat_beats, r_stat_stalls;

   always_ff @(posedge i_aclk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         r_stat_beats  <= '0;
         r_stat_stalls <= '0;
      end else begin
         if (w_pop)
            r_stat_beats <= r_stat_beats + 32'd1;
         if (o_md_axis_tvalid && !i_md_axis_tready)
            r_stat_stalls <= r_stat_stalls + 32'd1;
      end
   end

   assign o_stat_beats  = r_stat_beats;
   assign o_stat_stalls = r_stat_stalls;
`else
   assign o_stat_beats  = '0;
   assign o_stat_stalls = '0;
`endif

endmodule

// File: tb/tb_mac_operand_streamer.sv
// Randomized self-checking bench for mac_operand_streamer against a beat-list reference model.
module tb_mac_operand_streamer;

   localparam int DW = 32;
   localparam int AW = 10;
   localparam int LW = 16;

   typedef struct packed {
      logic [2*DW-1:0] data;
      logic            user;
      logic            last;
      logic [7:0]      id;
   } beat_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            cmd_valid = 1'b0;
   logic            cmd_ready;
   logic [AW-1:0]   cmd_w_base = '0, cmd_a_base = '0;
   logic [LW-1:0]   cmd_len = '0;
   logic            cmd_bias_en = 1'b0;
   logic [DW-1:0]   cmd_bias = '0;
   logic [7:0]      cmd_id = '0;
   logic            w_rd_en, a_rd_en;
   logic [AW-1:0]   w_rd_addr, a_rd_addr;
   logic [DW-1:0]   w_rd_data = '0, a_rd_data = '0;
   logic            tvalid, tuser, tlast;
   logic            tready = 1'b0;
   logic [2*DW-1:0] tdata;
   logic [7:0]      tid;
   logic [31:0]     stat_beats, stat_stalls;

   logic [DW-1:0]   wmem [1024];
   logic [DW-1:0]   amem [1024];

   beat_t           exp_q[$];
   beat_t           obs_q[$];
   logic [AW-1:0]   addr_q[$];
   int              checks = 0;
   int              fails = 0;
   int              cycle = 0;
   int              ready_mode = 1;
   int              acc_cycle, first_valid, ready_cycle;

   mac_operand_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
      .i_aclk(clk), .i_aresetn(rst_n),
      .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
      .i_cmd_w_base(cmd_w_base), .i_cmd_a_base(cmd_a_base), .i_cmd_len(cmd_len),
      .i_cmd_bias_en(cmd_bias_en), .i_cmd_bias(cmd_bias), .i_cmd_id(cmd_id),
      .o_w_rd_en(w_rd_en), .o_a_rd_en(a_rd_en),
      .o_w_rd_addr(w_rd_addr), .o_a_rd_addr(a_rd_addr),
      .i_w_rd_data(w_rd_data), .i_a_rd_data(a_rd_data),
      .o_md_axis_tvalid(tvalid), .i_md_axis_tready(tready),
      .o_md_axis_tdata(tdata), .o_md_axis_tuser(tuser),
      .o_md_axis_tlast(tlast), .o_md_axis_tid(tid),
      .o_stat_beats(stat_beats), .o_stat_stalls(stat_stalls)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   // Synchronous-read operand memories
   always @(posedge clk) begin
      if (w_rd_en) w_rd_data <= wmem[w_rd_addr];
      if (a_rd_en) a_rd_data <= amem[a_rd_addr];
   end

   // Sink readiness: 0 = held low, 1 = held high, otherwise random each cycle
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       tready = 1'b0;
         1:       tready = 1'b1;
         default: tready = 1'(($urandom_range(0, 1)));
      endcase
   end

   function automatic beat_t cur_beat();
      beat_t b;
      b.data = tdata;
      b.user = tuser;
      b.last = tlast;
      b.id   = tid;
      return b;
   endfunction

   // Reference: the list of beats a command must produce, derived directly from the command fields
   task automatic build_expected(input logic [AW-1:0] wb, input logic [AW-1:0] ab, input int len,
                                 input bit bias_en, input logic [DW-1:0] bias, input logic [7:0] id);
      beat_t b;
      exp_q.delete();
      if (bias_en) begin
         b.data = {32'h0, bias};
         b.user = 1'b1;
         b.last = (len == 0);
         b.id   = id;
         exp_q.push_back(b);
      end else if (len == 0) begin
         b.data = '0;
         b.user = 1'b0;
         b.last = 1'b1;
         b.id   = id;
         exp_q.push_back(b);
      end
      for (int k = 0; k < len; k++) begin
         b.data = {wmem[(int'(wb) + k) % 1024], amem[(int'(ab) + k) % 1024]};
         b.user = 1'b0;
         b.last = (k == len - 1);
         b.id   = id;
         exp_q.push_back(b);
      end
   endtask

   task automatic applyStimulus(input logic [AW-1:0] wb, input logic [AW-1:0] ab, input int len,
                                input bit bias_en, input logic [DW-1:0] bias, input logic [7:0] id,
                                output bit ok);
      ok = 1'b0;
      build_expected(wb, ab, len, bias_en, bias, id);
      @(posedge clk);
      #1;
      cmd_w_base  = wb;
      cmd_a_base  = ab;
      cmd_len     = LW'(len);
      cmd_bias_en = bias_en;
      cmd_bias    = bias;
      cmd_id      = id;
      cmd_valid   = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (cmd_ready) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      acc_cycle = cycle;
      cmd_valid = 1'b0;
   endtask

   task automatic collect(input int n, input int budget, output bit ok);
      ok = 1'b0;
      obs_q.delete();
      addr_q.delete();
      first_valid = -1;
      ready_cycle = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (tvalid && first_valid < 0) first_valid = cycle;
         if (w_rd_en) addr_q.push_back(w_rd_addr);
         if (tvalid && tready) obs_q.push_back(cur_beat());
         if (cmd_ready && obs_q.size() >= n) begin
            ready_cycle = cycle;
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b0 || tvalid !== 1'b0 || tdata !== '0 || tuser !== 1'b0 || tlast !== 1'b0 ||
          tid !== 8'h0 || w_rd_en !== 1'b0 || a_rd_en !== 1'b0 || w_rd_addr !== '0 || a_rd_addr !== '0 ||
          stat_beats !== 32'h0 || stat_stalls !== 32'h0) begin
         fails++;
         $display("[TB] FAIL reset_values: ready=%b valid=%b tdata=%h user=%b last=%b tid=%h rd_en=%b%b addr=%h/%h stats=%0d/%0d, required all zero",
                  cmd_ready, tvalid, tdata, tuser, tlast, tid, w_rd_en, a_rd_en, w_rd_addr, a_rd_addr, stat_beats, stat_stalls);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1) begin
         fails++;
         $display("[TB] FAIL ready_after_reset: got %b required 1", cmd_ready);
      end
   endtask

   task automatic test_bias_off();
      bit ok1, ok2;
      logic [7:0] id = 8'($urandom);
      ready_mode = 1;
      applyStimulus(10'h010, 10'h020, 4, 1'b0, '0, id, ok1);
      collect(4, 100, ok2);
      checks++;
      if (!ok1 || !ok2 || obs_q.size() != exp_q.size()) begin
         fails++;
         $display("[TB] FAIL bias_off_count: got %0d beats (acc=%0b done=%0b) required %0d", obs_q.size(), ok1, ok2, exp_q.size());
      end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            fails++;
            $display("[TB] FAIL bias_off_beat%0d: got %h required %h", i, obs_q[i], exp_q[i]);
         end
      end
      checks++;
      if (first_valid != acc_cycle + 2) begin
         fails++;
         $display("[TB] FAIL bias_off_latency: got %0d cycles required 2", first_valid - acc_cycle);
      end
      checks++;
      if (ready_cycle != acc_cycle + 4 + 3) begin
         fails++;
         $display("[TB] FAIL idle_to_idle: got %0d cycles required %0d", ready_cycle - acc_cycle, 7);
      end
   endtask

   task automatic test_bias_on();
      bit ok1, ok2;
      ready_mode = 1;
      applyStimulus(10'($urandom), 10'($urandom), 3, 1'b1, 32'h0002_4000, 8'h5A, ok1);
      collect(4, 100, ok2);
      checks++;
      if (!ok1 || !ok2 || obs_q.size() != exp_q.size()) begin
         fails++;
         $display("[TB] FAIL bias_on_count: got %0d beats required %0d", obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            fails++;
            $display("[TB] FAIL bias_on_beat%0d: got %h required %h", i, obs_q[i], exp_q[i]);
         end
      end
      checks++;
      if (first_valid != acc_cycle) begin
         fails++;
         $display("[TB] FAIL bias_visible: got %0d cycles after accept required 0", first_valid - acc_cycle);
      end
   endtask

   task automatic test_len_zero();
      bit ok1, ok2;
      ready_mode = 1;
      for (int v = 0; v < 2; v++) begin
         applyStimulus(10'($urandom), 10'($urandom), 0, v[0], 32'($urandom), 8'($urandom), ok1);
         collect(1, 50, ok2);
         checks++;
         if (!ok1 || !ok2 || obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
            fails++;
            $display("[TB] FAIL len_zero_bias%0d: got %0d beats first=%h required 1 beat %h",
                     v, obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : beat_t'(0), exp_q[0]);
         end
      end
   endtask

   task automatic test_addr_wrap();
      bit ok1, ok2;
      ready_mode = 1;
      applyStimulus(10'h3FE, 10'($urandom), 4, 1'b0, '0, 8'h21, ok1);
      collect(4, 100, ok2);
      checks++;
      if (!ok1 || !ok2 || addr_q.size() != 4) begin
         fails++;
         $display("[TB] FAIL wrap_reads: got %0d reads required 4", addr_q.size());
      end
      foreach (addr_q[i]) begin
         checks++;
         if (addr_q[i] !== AW'((10'h3FE + i) % 1024)) begin
            fails++;
            $display("[TB] FAIL wrap_addr%0d: got %h required %h", i, addr_q[i], AW'((10'h3FE + i) % 1024));
         end
      end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            fails++;
            $display("[TB] FAIL wrap_beat%0d: got %h required %h", i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      bit ok1, done;
      bit prev_stall;
      beat_t prev;
      int unstable;
      ready_mode = 2;
      applyStimulus(10'($urandom), 10'($urandom), 10, 1'($urandom), 32'($urandom), 8'($urandom), ok1);
      obs_q.delete();
      prev_stall = 1'b0;
      prev = '0;
      unstable = 0;
      done = 1'b0;
      for (int i = 0; i < 600 && !done; i++) begin
         @(negedge clk);
         if (prev_stall && (!tvalid || cur_beat() !== prev)) unstable++;
         if (tvalid && tready) obs_q.push_back(cur_beat());
         prev_stall = tvalid && !tready;
         prev = cur_beat();
         done = cmd_ready && (obs_q.size() >= exp_q.size());
      end
      checks++;
      if (unstable != 0) begin
         fails++;
         $display("[TB] FAIL stall_stability: got %0d changed cycles required 0", unstable);
      end
      checks++;
      if (!ok1 || !done || obs_q.size() != exp_q.size()) begin
         fails++;
         $display("[TB] FAIL backpressure_count: got %0d beats required %0d", obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            fails++;
            $display("[TB] FAIL backpressure_beat%0d: got %h required %h", i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      bit ok1, ok2;
      int len;
      ready_mode = 2;
      for (int c = 0; c < 3; c++) begin
         len = $urandom_range(1, 6);
         applyStimulus(10'($urandom), 10'($urandom), len, 1'($urandom), 32'($urandom), 8'(c + 8'h40), ok1);
         collect(exp_q.size(), 300, ok2);
         checks++;
         if (!ok1 || !ok2 || obs_q.size() != exp_q.size()) begin
            fails++;
            $display("[TB] FAIL b2b_cmd%0d_count: got %0d beats required %0d", c, obs_q.size(), exp_q.size());
         end
         foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
               fails++;
               $display("[TB] FAIL b2b_cmd%0d_beat%0d: got %h required %h", c, i, obs_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_reset_midstream();
      bit ok1, ok2;
      ready_mode = 1;
      applyStimulus(10'($urandom), 10'($urandom), 8, 1'b0, '0, 8'h77, ok1);
      obs_q.delete();
      for (int i = 0; i < 100 && obs_q.size() < 3; i++) begin
         @(negedge clk);
         if (tvalid && tready) obs_q.push_back(cur_beat());
      end
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (!ok1 || obs_q.size() != 3 || tvalid !== 1'b0 || cmd_ready !== 1'b0) begin
         fails++;
         $display("[TB] FAIL midstream_reset: got valid=%b ready=%b beats=%0d required valid=0 ready=0 beats=3",
                  tvalid, cmd_ready, obs_q.size());
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1 || tvalid !== 1'b0) begin
         fails++;
         $display("[TB] FAIL post_reset_idle: got ready=%b valid=%b required ready=1 valid=0", cmd_ready, tvalid);
      end
      applyStimulus(10'($urandom), 10'($urandom), 5, 1'b1, 32'($urandom), 8'h78, ok1);
      collect(6, 100, ok2);
      checks++;
      if (!ok1 || !ok2 || obs_q.size() != exp_q.size()) begin
         fails++;
         $display("[TB] FAIL post_reset_count: got %0d beats required %0d", obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            fails++;
            $display("[TB] FAIL post_reset_beat%0d: got %h required %h", i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_stats();
      bit ok1, ok2, seen;
      logic [31:0] exp_beats, exp_stalls;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      ready_mode = 0;
      applyStimulus(10'($urandom), 10'($urandom), 5, 1'b1, 32'($urandom), 8'h99, ok1);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = tvalid;
      end
      repeat (2) @(negedge clk);
      ready_mode = 1;
      collect(6, 100, ok2);
`ifdef MAC_STREAMER_STATS_EN
      exp_beats  = 32'(exp_q.size());
      exp_stalls = 32'd3;
`else
      exp_beats  = 32'd0;
      exp_stalls = 32'd0;
`endif
      checks++;
      if (!ok1 || !ok2 || !seen || stat_beats !== exp_beats || stat_stalls !== exp_stalls) begin
         fails++;
         $display("[TB] FAIL stats: got beats=%0d stalls=%0d required beats=%0d stalls=%0d",
                  stat_beats, stat_stalls, exp_beats, exp_stalls);
      end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            fails++;
            $display("[TB] FAIL stats_beat%0d: got %h required %h", i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         wmem[i] = $urandom;
         amem[i] = $urandom;
      end
      test_reset();
      test_bias_off();
      test_bias_on();
      test_len_zero();
      test_addr_wrap();
      test_backpressure();
      test_back_to_back();
      test_reset_midstream();
      test_stats();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/mac_operand_streamer.md
# mac_operand_streamer

Sequencer feeding the staged MAC's SD_AXIS slave port. On each command it reads LEN weight/activation operand pairs from two synchronous-read operand memories and streams them as {weight, activation} beats. The optional first bias beat carries TUSER=1, and the final beat carries TLAST and the command's TID. It sits between the layer controller (command side) and staged_mac, and absorbs downstream backpressure with a small output FIFO.

## Interface
- DATA_WIDTH, 32, operand width; TDATA is 2*DATA_WIDTH
- ADDR_WIDTH, 10, operand memory address width
- LEN_WIDTH, 16, width of the command length field
- ACLK  in  1  clock; all logic rising-edge
- ARESETN  in  1  reset, asynchronous assert, active-low
- CMD_VALID  in  1  command valid
- CMD_READY  out  1  command ready; high only in IDLE
- CMD_W_BASE  in  ADDR_WIDTH  first weight address
- CMD_A_BASE  in  ADDR_WIDTH  first activation address
- CMD_LEN  in  LEN_WIDTH  number of operand pairs (0 legal)
- CMD_BIAS_EN  in  1  emit bias beat first
- CMD_BIAS  in  DATA_WIDTH  bias value
- CMD_ID  in  8  TID for every beat of this command
- W_RD_EN / A_RD_EN  out  1  memory read enables
- W_RD_ADDR / A_RD_ADDR  out  ADDR_WIDTH  read addresses
- W_RD_DATA / A_RD_DATA  in  DATA_WIDTH  read data, valid the cycle after RD_EN
- MD_AXIS_TVALID  out  1  beat valid
- MD_AXIS_TREADY  in  1  MAC ready (SD_AXIS_TREADY)
- MD_AXIS_TDATA  out  2*DATA_WIDTH  {weight, activation}
- MD_AXIS_TUSER  out  1  accumulator-init beat
- MD_AXIS_TLAST  out  1  last beat of the dot product
- MD_AXIS_TID  out  8  command ID
- STAT_BEATS  out  32  beats transferred (see Configuration)
- STAT_STALLS  out  32  cycles with TVALID && !TREADY

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE: CMD_READY=1. On a CMD_VALID&&CMD_READY edge, latch all CMD_* fields, clear the issue counter, and go to ISSUE.
- Bias beat:
  - If BIAS_EN=1, at the accept edge push {0, CMD_BIAS} with TUSER=1 into the FIFO.
  - TLAST=1 on this beat only if LEN=0.
- LEN=0 with BIAS_EN=0: push one beat {0, 0}, TUSER=0, TLAST=1, then go directly to DRAIN.
- ISSUE:
  - Each cycle with credit>0, assert W_RD_EN and A_RD_EN together with addresses base+k, where k counts 0..LEN-1.
  - Addresses wrap modulo 2^ADDR_WIDTH.
  - The returned pair is pushed the next edge as {W_RD_DATA, A_RD_DATA}, TUSER=0, TLAST=(k==LEN-1).
  - After issuing k=LEN-1, go to DRAIN.
- Credit = FIFO free entries minus reads in flight (0 or 1). Read enables are never asserted when credit=0, so the FIFO never overflows.
- DRAIN: wait until the FIFO is empty and no read is in flight, then return to IDLE. The next command cannot be accepted until the TLAST beat has transferred.
- Output FIFO: depth 4. The head drives MD_AXIS_*, and TVALID = !empty.
- A beat pops on TVALID&&TREADY. A push and pop in the same cycle are both honoured.
- TDATA, TUSER, TLAST, and TID must stay stable while TVALID && !TREADY.

## Timing
- Reset values: CMD_READY=0 while ARESETN=0 and 1 after release; TVALID=0, TDATA=0, TUSER=0, TLAST=0, TID=0, RD_EN=0, RD_ADDR=0, STAT_*=0.
- ARESETN low mid-command: the FIFO, FSM, and counters clear asynchronously and TVALID drops immediately. No partial stream resumes after reset.
- Accept edge E0 behaviour:
  - Bias beat visible (TVALID=1) after E0.
  - First read issued in cycle E0..E1.
  - Data beat 0 is pushed at E2 and visible after E2.
- Throughput: 1 beat/cycle while TREADY is held high, with no bubble between the bias beat and beat 0.
- Minimum IDLE-to-IDLE time for LEN=N, BIAS_EN=0 with TREADY=1: N+3 cycles.
- TREADY low: issue halts within 1 cycle of credit reaching 0. On TREADY rising, issue resumes the following cycle.

## Configuration
- MAC_STREAMER_STATS_EN defined:
  - STAT_BEATS increments on every TVALID&&TREADY.
  - STAT_STALLS increments on every cycle with TVALID && !TREADY.
  - Both counters wrap at 2^32 and clear only on reset.
- Not defined: both STAT ports are constant 0 and no counter logic is built.

## Test plan
- Bias off: BIAS_EN=0, LEN=4, W_BASE=0x10, A_BASE=0x20, memories preloaded, TREADY=1 -> 4 beats on consecutive cycles with TDATA={W[0x10+k], A[0x20+k]}, TLAST only on beat 3, TID=CMD_ID, first TVALID 2 cycles after accept.
- Bias on: BIAS_EN=1, BIAS=0x00024000, LEN=3 -> beat 0 is {0, 0x00024000} with TUSER=1, followed by 3 data beats with TUSER=0 and TLAST on the last; staged_mac output matches the scoreboard.
- Backpressure: LEN=10 with random TREADY -> no beat lost or duplicated, outputs stable while stalled, RD_EN never asserted with credit=0.
- Edge cases: LEN=0 with BIAS_EN=0 -> single beat {0, 0}, TLAST=1. LEN=0 with BIAS_EN=1 -> single bias beat with TUSER=1, TLAST=1. W_BASE=0x3FE with LEN=4 -> addresses 0x3FE, 0x3FF, 0x000, 0x001.
- Reset mid-stream: assert ARESETN low after beat 2 of LEN=8 -> TVALID=0 immediately, CMD_READY=1 after release, and a new command streams correctly.
- Stats (macro defined): LEN=5, BIAS_EN=1, TREADY low for 3 cycles while valid -> STAT_BEATS=6, STAT_STALLS=3.
